nf_sim_platform_ctrl: RTL and testbench

Board-level control core for the simulation top of the NetFPGA data-plane platform. It sequences the SI5324 clock-synthesizer reset and programs a fixed 4-entry register table over a bit-banged I2C master. It also drives two status LEDs: a heartbeat and a programming-done indicator. The PCIe and 10G datapaths are outside this block.

---
 rtl/nf_sim_platform_ctrl_if.sv | 21 ++
 rtl/nf_sim_platform_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_nf_sim_platform_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/nf_sim_platform_ctrl_if.sv
// Board-side outputs of the platform control core: SI5324 SCL/reset and the two status LEDs.
interface nf_sim_platform_ctrl_if;
  logic i2c_clk;
  logic i2c_reset;
  logic led_0;
  logic led_1;

  modport master (
    output i2c_clk,
    output i2c_reset,
    output led_0,
    output led_1
  );

  modport slave (
    input i2c_clk,
    input i2c_reset,
    input led_0,
    input led_1
  );
endinterface

// File: rtl/nf_sim_platform_ctrl.sv
// Platform control core: SI5324 reset sequencing, fixed 4-entry register
// programming over a bit-banged I2C master, heartbeat and done LEDs.
// Build macro I2C_ACK_CHECK_EN: a NACK ends programming with STOP then ERR.
module nf_sim_platform_ctrl #(
  parameter int unsigned CLK_DIV    = 125,
  parameter int unsigned RST_CYCLES = 1000,
  parameter logic [6:0]  SLAVE_ADDR = 7'h68,
  parameter int unsigned HB_BITS    = 27
) (
  input  logic                  clk_ref,
  input  logic                  sys_reset_n,
  nf_sim_platform_ctrl_if.master brd,
  inout  wire                   i2c_data
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_HOLD,
    S_SETTLE,
    S_START,
    S_BYTE,
    S_ACK,
    S_STOP,
    S_GAP,
    S_DONE,
    S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         ph_q, ph_d;
  logic [2:0]         bit_q, bit_d;
  logic [1:0]         byte_q, byte_d;
  logic [1:0]         idx_q, idx_d;
  logic               rst_out_q, rst_out_d;
  logic               scl_q, scl_d;
  logic               sda_low_q, sda_low_d;
  logic               done_q, done_d;
  logic [HB_BITS-1:0] hb_q, hb_d;
`ifdef I2C_ACK_CHECK_EN
  logic               nack_q, nack_d;
`endif

  logic               bus_active_c;
  logic               tick_c;
  logic               slot_end_c;
  logic [7:0]         tx_byte_c;

  // Byte sel of table entry idx: 0 = address+write, 1 = register, 2 = data.
  function automatic logic [7:0] entry_byte(input logic [1:0] idx, input logic [1:0] sel);
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    case (idx)
      2'd0:    begin reg_addr = 8'd0;   reg_data = 8'h54; end
      2'd1:    begin reg_addr = 8'd2;   reg_data = 8'hA2; end
      2'd2:    begin reg_addr = 8'd6;   reg_data = 8'h2F; end
      default: begin reg_addr = 8'd136; reg_data = 8'h40; end
    endcase
    case (sel)
      2'd0:    entry_byte = {SLAVE_ADDR, 1'b0};
      2'd1:    entry_byte = reg_addr;
      default: entry_byte = reg_data;
    endcase
  endfunction

  // State and counter registers; outputs are flops loaded from next-state values.
  always_ff @(posedge clk_ref or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      div_q     <= '0;
      ph_q      <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      idx_q     <= '0;
      rst_out_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
      done_q    <= 1'b0;
      hb_q      <= '0;
`ifdef I2C_ACK_CHECK_EN
      nack_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
      done_q    <= done_d;
      hb_q      <= hb_d;
`ifdef I2C_ACK_CHECK_EN
      nack_q    <= nack_d;
`endif
    end
  end

  // Next-state sequencing, quarter-bit ticking, and the bus/LED levels for the next cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = '0;
    ph_d         = ph_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    idx_d        = idx_q;
    rst_out_d    = rst_out_q;
    hb_d         = hb_q + HB_BITS'(1);
`ifdef I2C_ACK_CHECK_EN
    nack_d       = nack_q;
`endif
    tick_c       = 1'b0;
    slot_end_c   = 1'b0;
    scl_d        = 1'b1;
    sda_low_d    = 1'b0;
    done_d       = 1'b0;
    tx_byte_c    = 8'h00;

    bus_active_c = (state_q == S_START) || (state_q == S_BYTE) || (state_q == S_ACK) ||
                   (state_q == S_STOP)  || (state_q == S_GAP);

    // Divider runs only while the bus is being sequenced, so every transfer starts phase-aligned.
    if (bus_active_c) begin
      if (div_q == DIV_W'(CLK_DIV - 1)) begin
        tick_c = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    if (tick_c) begin
      ph_d       = ph_q + 2'd1;
      slot_end_c = (ph_q == 2'd3);
    end

    case (state_q)
      S_HOLD: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          cnt_d     = '0;
          rst_out_d = 1'b1;
          state_d   = S_SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_START: begin
`ifdef I2C_ACK_CHECK_EN
        nack_d = 1'b0;
`endif
        if (slot_end_c) begin
          byte_d  = 2'd0;
          bit_d   = 3'd7;
          state_d = S_BYTE;
        end
      end
      S_BYTE: begin
        if (slot_end_c) begin
          if (bit_q == 3'd0) begin
            state_d = S_ACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      S_ACK: begin
`ifdef I2C_ACK_CHECK_EN
        // Sample at the end of the second SCL-high quarter; released line reads 1 via pull-up.
        if (tick_c && (ph_q == 2'd2)) begin
          nack_d = i2c_data;
        end
`endif
        if (slot_end_c) begin
`ifdef I2C_ACK_CHECK_EN
          if ((byte_q == 2'd2) || nack_q) begin
`else
          if (byte_q == 2'd2) begin
`endif
            state_d = S_STOP;
          end else begin
            byte_d  = byte_q + 2'd1;
            bit_d   = 3'd7;
            state_d = S_BYTE;
          end
        end
      end
      S_STOP: begin
        if (slot_end_c) begin
`ifdef I2C_ACK_CHECK_EN
          state_d = nack_q ? S_ERR : S_GAP;
`else
          state_d = S_GAP;
`endif
        end
      end
      S_GAP: begin
        if (slot_end_c) begin
          if (idx_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_START;
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_HOLD;
    endcase

    // Bus levels for the slot/phase being entered; SDA only moves on the SCL-low quarters.
    case (state_d)
      S_START: begin
        sda_low_d = 1'b1;
        scl_d     = (ph_d == 2'd0);
      end
      S_BYTE: begin
        tx_byte_c = entry_byte(idx_d, byte_d);
        scl_d     = (ph_d == 2'd1) || (ph_d == 2'd2);
        sda_low_d = ~tx_byte_c[bit_d];
      end
      S_ACK: begin
        scl_d = (ph_d == 2'd1) || (ph_d == 2'd2);
      end
      S_STOP: begin
        scl_d     = (ph_d != 2'd0);
        sda_low_d = (ph_d == 2'd0) || (ph_d == 2'd1);
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
    endcase
  end

  // Output mapping: SDA is open-drain, everything else push-pull from flops.
  assign i2c_data      = sda_low_q ? 1'b0 : 1'bz;
  assign brd.i2c_clk   = scl_q;
  assign brd.i2c_reset = rst_out_q;
  assign brd.led_0     = hb_q[HB_BITS-1];
  assign brd.led_1     = done_q;

endmodule

// File: tb/tb_nf_sim_platform_ctrl.sv
// Self-checking bench for nf_sim_platform_ctrl: bus decoder, optional ACKing slave,
// reference model of the expected byte stream, timing of reset/START/LEDs.
`timescale 1ns/1ps
module tb_nf_sim_platform_ctrl;

  localparam int CLK_DIV    = 2;
  localparam int RST_CYCLES = 16;
  localparam int HB_BITS    = 4;
  localparam int SLOT       = 4 * CLK_DIV;
  localparam int DONE_CYC   = 2 * RST_CYCLES + 120 * SLOT;
  localparam int NO_NACK    = 99;
`ifdef I2C_ACK_CHECK_EN
  localparam bit ACK_CHECK  = 1'b1;
`else
  localparam bit ACK_CHECK  = 1'b0;
`endif

  logic clk_ref     = 1'b0;
  logic sys_reset_n = 1'b0;
  logic slave_low   = 1'b0;
  wire  i2c_data;

  pullup (i2c_data);
  assign i2c_data = slave_low ? 1'b0 : 1'bz;

  nf_sim_platform_ctrl_if bif ();

  nf_sim_platform_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .RST_CYCLES (RST_CYCLES),
    .SLAVE_ADDR (7'h68),
    .HB_BITS    (HB_BITS)
  ) dut (
    .clk_ref     (clk_ref),
    .sys_reset_n (sys_reset_n),
    .brd         (bif),
    .i2c_data    (i2c_data)
  );

  always #5 clk_ref = ~clk_ref;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected j-th byte on the bus after reset release.
  function automatic logic [7:0] exp_byte(input int j);
    logic [7:0] regs [4];
    logic [7:0] dats [4];
    regs = '{8'h00, 8'h02, 8'h06, 8'h88};
    dats = '{8'h54, 8'hA2, 8'h2F, 8'h40};
    case (j % 3)
      0:       return 8'hD0;
      1:       return regs[j / 3];
      default: return dats[j / 3];
    endcase
  endfunction

  // Bus decoder and slave, sampled on the falling clock edge.
  logic [7:0] rx_q [$];
  logic [7:0] shreg   = '0;
  logic       scl_p   = 1'b1;
  logic       sda_p   = 1'b1;
  int         starts  = 0;
  int         stops   = 0;
  int         rises   = 0;
  int         viol    = 0;
  int         bit_cnt = 0;
  bit         slave_en = 1'b0;
  int         nack_at  = NO_NACK;

  always @(negedge clk_ref) begin
    logic scl_n;
    logic sda_n;
    scl_n = bif.i2c_clk;
    sda_n = i2c_data;
    if (!sys_reset_n) begin
      rx_q.delete();
      starts = 0; stops = 0; rises = 0; viol = 0; bit_cnt = 0;
      scl_p = 1'b1; sda_p = 1'b1; slave_low = 1'b0;
    end else begin
      if ((scl_n != scl_p) && (sda_n != sda_p)) begin
        viol++;
      end else if (scl_p && scl_n && (sda_n != sda_p)) begin
        if (!sda_n) begin
          starts++;
          bit_cnt = 0;
        end else begin
          stops++;
        end
      end else if (!scl_p && scl_n) begin
        rises++;
        if (bit_cnt < 8) begin
          shreg = {shreg[6:0], sda_n};
          bit_cnt++;
        end else begin
          rx_q.push_back(shreg);
          bit_cnt = 0;
        end
      end else if (scl_p && !scl_n) begin
        slave_low = slave_en && (bit_cnt == 8) && (rx_q.size() != nack_at);
      end
      scl_p = scl_n;
      sda_p = sda_n;
    end
  end

  // One reset-release-to-idle sequence; abort_cyc > 0 pulls reset mid-run instead.
  task automatic run_seq(input bit slv, input int nack, input int abort_cyc);
    int  first_nack;
    int  nbytes;
    int  txns;
    bit  expect_done;
    int  idle_bad;
    int  hb_a;
    int  hb_b;
    bit  aborted;
    int  ncmp;

    first_nack  = !slv ? 0 : ((nack < 12) ? nack : NO_NACK);
    nbytes      = (ACK_CHECK && first_nack < 12) ? first_nack + 1 : 12;
    expect_done = !ACK_CHECK || (first_nack == NO_NACK);
    txns        = (nbytes + 2) / 3;
    idle_bad    = 0;
    aborted     = 1'b0;
    hb_a        = $urandom_range(1, 300);
    hb_b        = $urandom_range(301, 900);

    @(negedge clk_ref);
    sys_reset_n = 1'b0;
    slave_en    = slv;
    nack_at     = nack;
    repeat ($urandom_range(2, 5)) @(negedge clk_ref);
    check("rst_i2c_reset", bif.i2c_reset, 0);
    check("rst_scl", bif.i2c_clk, 1);
    check("rst_sda", i2c_data, 1);
    check("rst_led0", bif.led_0, 0);
    check("rst_led1", bif.led_1, 0);
    sys_reset_n = 1'b1;

    for (int c = 1; c <= DONE_CYC + 40; c++) begin
      @(negedge clk_ref);
      if (c < 2 * RST_CYCLES && (bif.i2c_clk !== 1'b1 || i2c_data !== 1'b1)) idle_bad++;
      if (c == RST_CYCLES - 1) check("i2c_reset_held", bif.i2c_reset, 0);
      if (c == RST_CYCLES)     check("i2c_reset_rise", bif.i2c_reset, 1);
      if (c == 2 * RST_CYCLES - 1) check("sda_before_start", i2c_data, 1);
      if (c == 2 * RST_CYCLES) begin
        check("bus_idle_pre_start", idle_bad, 0);
        check("start_sda_low", i2c_data, 0);
        check("start_scl_high", bif.i2c_clk, 1);
      end
      if (c == hb_a || c == hb_b)
        check("heartbeat", bif.led_0, ((c % (1 << HB_BITS)) >= (1 << (HB_BITS - 1))) ? 1 : 0);
      if (expect_done && c == DONE_CYC - 1) check("led1_before_done", bif.led_1, 0);
      if (expect_done && c == DONE_CYC)     check("led1_at_done", bif.led_1, 1);
      if (c == abort_cyc) begin
        sys_reset_n = 1'b0;
        #1;
        check("abort_i2c_reset", bif.i2c_reset, 0);
        check("abort_scl", bif.i2c_clk, 1);
        check("abort_sda", i2c_data, 1);
        check("abort_led0", bif.led_0, 0);
        check("abort_led1", bif.led_1, 0);
        aborted = 1'b1;
        break;
      end
    end

    if (!aborted) begin
      check("byte_count", rx_q.size(), nbytes);
      ncmp = (rx_q.size() < nbytes) ? rx_q.size() : nbytes;
      for (int j = 0; j < ncmp; j++) check($sformatf("byte%0d", j), rx_q[j], exp_byte(j));
      check("start_count", starts, txns);
      check("stop_count", stops, txns);
      check("scl_rises", rises, 9 * nbytes + txns);
      check("sda_scl_same_edge", viol, 0);
      check("led1_final", bif.led_1, expect_done ? 1 : 0);
      check("scl_idle_final", bif.i2c_clk, 1);
      check("sda_idle_final", i2c_data, 1);
      check("i2c_reset_final", bif.i2c_reset, 1);
    end
  endtask

  initial begin
    run_seq(1'b0, NO_NACK, 0);
    run_seq(1'b1, NO_NACK, 0);
    run_seq(1'b1, NO_NACK, $urandom_range(113, 160));
    run_seq(1'b0, NO_NACK, 0);
    for (int r = 0; r < 3; r++) begin
      run_seq(1'($urandom_range(0, 1)), $urandom_range(0, 13), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
